// File: rtl/marker_sync.sv
// marker_sync - receive-side frame synchronizer for the DTFM marker format.
// Finds the 4-word marker group (M/nM + B/nB) in the 11-bit code word stream,
// acquires and holds frame lock with a flywheel, and emits payload words tagged
// with their word index and group number one clock after they arrive.
// Optional build macro SYNC_STAT_EN adds a slip counter (outSlipCnt) and a
// per-bad-group pulse in LOCK (outMissFlag).
module marker_sync #(
  parameter int FRAME_WORDS = 1024,
  parameter int CONFIRM     = 2,
  parameter int MISS_LIMIT  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] inWord,
  input  logic        inValid,
  output logic [10:0] outData,
  output logic        outValid,
  output logic [9:0]  outWordNum,
  output logic [1:0]  outGroup,
`ifdef SYNC_STAT_EN
  output logic [15:0] outSlipCnt,
  output logic        outMissFlag,
`endif
  output logic        locked
);

  localparam logic [30:0] MARK_M = 31'b1111100110100100001010111011000;
  localparam logic [12:0] MARK_B = 13'b1111100110101;

  // hit holds 1..CONFIRM, miss holds 0..MISS_LIMIT-1
  localparam int HIT_W  = (CONFIRM < 2) ? 1 : $clog2(CONFIRM + 1);
  localparam int MISS_W = (MISS_LIMIT < 2) ? 1 : $clog2(MISS_LIMIT);

  localparam logic [9:0]        LAST_WORD = 10'(FRAME_WORDS - 1);
  localparam logic [HIT_W-1:0]  HIT_LOCK  = HIT_W'(CONFIRM);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCK   = 2'd2
  } state_t;

  // Full 44-bit marker of group g: {Ms, Bs}; the four code words are
  // consecutive 11-bit slices of it, most significant first.
  function automatic logic [43:0] marker_all(input logic [1:0] g);
    logic [30:0] ms;
    logic [12:0] bs;
    ms = g[0] ? ~MARK_M : MARK_M;
    bs = g[1] ? ~MARK_B : MARK_B;
    return {ms, bs};
  endfunction

  // Marker code word idx (0..3) of group g.
  function automatic logic [10:0] marker_word(input logic [1:0] g, input logic [1:0] idx);
    logic [43:0] all;
    logic [10:0] w;
    all = marker_all(g);
    case (idx)
      2'd0:    w = all[43:33];
      2'd1:    w = all[32:22];
      2'd2:    w = all[21:11];
      default: w = all[10:0];
    endcase
    return w;
  endfunction

  state_t              r_state, w_state_nx;
  logic [32:0]         r_win, w_win_nx;     // last three valid words, oldest on top
  logic [1:0]          r_fill, w_fill_nx;   // words in window since it was cleared (saturates at 3)
  logic [9:0]          r_wcnt, w_wcnt_nx;
  logic [1:0]          r_grp, w_grp_nx;
  logic [HIT_W-1:0]    r_hit, w_hit_nx;
  logic [MISS_W-1:0]   r_miss, w_miss_nx;
  logic                r_bad, w_bad_nx;

  logic                w_match;
  logic [1:0]          w_match_grp;
  logic                w_in_marker;
  logic                w_grp_end;
  logic                w_grp_bad;
  logic [10:0]         w_mark_exp;
  logic                w_emit;

  assign w_in_marker = (r_wcnt < 10'd4);
  assign w_grp_end   = (r_wcnt == 10'd3);
  assign w_mark_exp  = marker_word(r_grp, r_wcnt[1:0]);
  assign w_grp_bad   = r_bad | (inWord != w_mark_exp);
  assign w_emit      = inValid && (r_state == ST_LOCK) && !w_in_marker;
  assign locked      = (r_state == ST_LOCK);

  // Window compare against all four group markers; iterating downwards lets the lowest group win.
  always_comb begin
    w_match     = 1'b0;
    w_match_grp = 2'd0;
    for (int g = 3; g >= 0; g--) begin
      if ({r_win, inWord} == marker_all(2'(g))) begin
        w_match     = 1'b1;
        w_match_grp = 2'(g);
      end
    end
  end

  // State and counter register bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_SEARCH;
      r_win   <= '0;
      r_fill  <= '0;
      r_wcnt  <= '0;
      r_grp   <= '0;
      r_hit   <= '0;
      r_miss  <= '0;
      r_bad   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_win   <= w_win_nx;
      r_fill  <= w_fill_nx;
      r_wcnt  <= w_wcnt_nx;
      r_grp   <= w_grp_nx;
      r_hit   <= w_hit_nx;
      r_miss  <= w_miss_nx;
      r_bad   <= w_bad_nx;
    end
  end

  // Next-state logic: search window, flywheel counters, group verdicts.
  always_comb begin
    w_state_nx = r_state;
    w_win_nx   = r_win;
    w_fill_nx  = r_fill;
    w_wcnt_nx  = r_wcnt;
    w_grp_nx   = r_grp;
    w_hit_nx   = r_hit;
    w_miss_nx  = r_miss;
    w_bad_nx   = r_bad;
    if (inValid) begin
      unique case (r_state)
        ST_SEARCH: begin
          w_win_nx = {r_win[21:0], inWord};
          if (r_fill != 2'd3) begin
            w_fill_nx = r_fill + 2'd1;
          end
          // A match needs three words already in the window plus the current one.
          if (w_match && (r_fill == 2'd3)) begin
            w_state_nx = ST_CHECK;
            w_grp_nx   = w_match_grp;
            w_wcnt_nx  = 10'd4;
            w_hit_nx   = HIT_W'(1);
            w_miss_nx  = '0;
            w_bad_nx   = 1'b0;
          end
        end
        default: begin
          // Flywheel: word index wraps at the period end and advances the group.
          if (r_wcnt == LAST_WORD) begin
            w_wcnt_nx = '0;
            w_grp_nx  = r_grp + 2'd1;
          end else begin
            w_wcnt_nx = r_wcnt + 10'd1;
          end
          if (w_in_marker) begin
            w_bad_nx = w_grp_bad;
          end
          if (w_grp_end) begin
            w_bad_nx = 1'b0;
            if (r_state == ST_CHECK) begin
              if (w_grp_bad) begin
                w_state_nx = ST_SEARCH;
                w_win_nx   = '0;
                w_fill_nx  = '0;
              end else if (r_hit == HIT_LOCK) begin
                w_state_nx = ST_LOCK;
                w_miss_nx  = '0;
              end else begin
                w_hit_nx = r_hit + HIT_W'(1);
              end
            end else begin
              if (!w_grp_bad) begin
                w_miss_nx = '0;
              end else if (r_miss == MISS_LAST) begin
                w_state_nx = ST_SEARCH;
                w_win_nx   = '0;
                w_fill_nx  = '0;
                w_miss_nx  = '0;
              end else begin
                w_miss_nx = r_miss + MISS_W'(1);
              end
            end
          end
        end
      endcase
    end
  end

  // Payload output register: one-clock latency, tag fields hold between pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outValid   <= 1'b0;
      outData    <= '0;
      outWordNum <= '0;
      outGroup   <= '0;
    end else begin
      outValid <= w_emit;
      if (w_emit) begin
        outData    <= inWord;
        outWordNum <= r_wcnt;
        outGroup   <= r_grp;
      end
    end
  end

`ifdef SYNC_STAT_EN
  logic        w_miss_evt;
  logic        w_slip;
  logic [15:0] r_slip_cnt;
  logic        r_miss_flag;

  assign w_miss_evt = inValid && (r_state == ST_LOCK) && w_grp_end && w_grp_bad;
  assign w_slip     = w_miss_evt && (r_miss == MISS_LAST);

  // Lock statistics: saturating slip count and a pulse per bad group while locked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_slip_cnt  <= '0;
      r_miss_flag <= 1'b0;
    end else begin
      r_miss_flag <= w_miss_evt;
      if (w_slip && (r_slip_cnt != 16'hFFFF)) begin
        r_slip_cnt <= r_slip_cnt + 16'd1;
      end
    end
  end

  assign outSlipCnt  = r_slip_cnt;
  assign outMissFlag = r_miss_flag;
`endif

endmodule
